// File: rtl/regfile_win_pkg.sv
// Shared state encoding and default sizing for the windowed register file.
package regfile_win_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_RD = 3;

endpackage

// File: rtl/regfile_win_ctrl.sv
// Burst write sequencer: steers single writes or burst beats onto one write port, 0-cycle decode.
// Beats without reg_write stall the burst pointer; the upstream source paces the data.
module regfile_win_ctrl
  import regfile_win_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_enable,
  input  logic              reg_write,
  input  logic              burst_start,
  input  logic [ADDR_W-1:0] burst_len,
  input  logic [ADDR_W-1:0] write_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;

  // In BURST the address comes from ptr and write_addr/burst_start are ignored.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = write_addr;
    if (state == IDLE) begin
      wr_en = reg_enable & reg_write & ~burst_start;
    end else begin
      wr_en   = reg_enable & reg_write;
      wr_addr = ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reg_enable && burst_start) begin
            ptr       <= write_addr;
            remaining <= burst_len;
            state     <= BURST;
            busy      <= 1'b1;
          end
        end
        BURST: begin
          if (reg_enable && reg_write) begin
            ptr <= ptr + ADDR_W'(1);
            if (remaining == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              remaining <= remaining - ADDR_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_win.sv
// Register file with NUM_RD consecutive wrapping read lanes and write-first bypass; 1-cycle read latency.
// No backpressure: every enabled request is accepted, burst pacing is via reg_write.
module regfile_win
  import regfile_win_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_enable,
  input  logic                     reg_write,
  input  logic                     burst_start,
  input  logic [ADDR_W-1:0]        burst_len,
  input  logic [ADDR_W-1:0]        write_addr,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        src_addr,
  output logic [NUM_RD*DATA_W-1:0] src,
  output logic                     rd_valid,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [ADDR_W-1:0]        lane_addr [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] lane_dat;

  regfile_win_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .reg_enable (reg_enable),
    .reg_write  (reg_write),
    .burst_start(burst_start),
    .burst_len  (burst_len),
    .write_addr (write_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .busy       (busy)
  );

  // Lane addresses wrap naturally in ADDR_W bits; a lane hitting the live write sees the new data.
  always_comb begin
    lane_dat = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      lane_addr[k] = src_addr + ADDR_W'(k);
      if (wr_en && (lane_addr[k] == wr_addr)) begin
        lane_dat[k*DATA_W +: DATA_W] = write_data;
      end else begin
        lane_dat[k*DATA_W +: DATA_W] = mem[lane_addr[k]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      src      <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= write_data;
      end
      rd_valid <= reg_enable;
      if (reg_enable) begin
        src <= lane_dat;
      end
    end
  end

endmodule

// File: tb/tb_regfile_win.sv
// Directed bench for regfile_win: reads are scoreboarded, control/reset state checked inline.
module tb_regfile_win;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int SW = NR * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_enable = 1'b0;
  logic          reg_write = 1'b0;
  logic          burst_start = 1'b0;
  logic [AW-1:0] burst_len = '0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic [AW-1:0] src_addr = '0;
  logic [SW-1:0] src;
  logic          rd_valid;
  logic          busy;

  typedef struct {
    bit            chk;
    logic [SW-1:0] dat;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  regfile_win #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_enable (reg_enable),
    .reg_write  (reg_write),
    .burst_start(burst_start),
    .burst_len  (burst_len),
    .write_addr (write_addr),
    .write_data (write_data),
    .src_addr   (src_addr),
    .src        (src),
    .rd_valid   (rd_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] l3(input logic [DW-1:0] a0, a1, a2);
    return {a2, a1, a0};
  endfunction

  // Contents left by the full-depth burst: beat i (data 0x1000+i) lands at (100+i) mod 128.
  function automatic logic [DW-1:0] fd(input int a);
    return 32'h1000 + 32'((a + 28) % 128);
  endfunction

  // Monitor: every rd_valid pops one expected read.
  exp_t e;
  always @(negedge clk) begin
    if (rd_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: rd_valid=1 src=%h, required no pending read", src);
      end else begin
        e = q.pop_front();
        if (e.chk) begin
          total++;
          if (src !== e.dat) begin
            bad++;
            $display("FAIL read_data: src=%h required=%h", src, e.dat);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit en, input bit wr, input bit bs, input logic [AW-1:0] len,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [AW-1:0] sa,
                     input bit ck, input logic [SW-1:0] ex);
    reg_enable  = en;
    reg_write   = wr;
    burst_start = bs;
    burst_len   = len;
    write_addr  = wa;
    write_data  = wd;
    src_addr    = sa;
    if (en) q.push_back('{ck, ex});
    tick();
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc(1, 1, 0, 0, a, d, 0, 0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [SW-1:0] ex);
    cyc(1, 0, 0, 0, 0, 0, a, 1, ex);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int bc;

  initial begin
    tick();
    tick();
    check("reset_src", src, '0);
    check("reset_rd_valid", SW'(rd_valid), '0);
    check("reset_busy", SW'(busy), '0);
    rst = 1'b0;

    // Single writes, then a read of lanes 0..2; then a hold cycle.
    for (int i = 0; i < 5; i++) wr1(AW'(i), 32'hFFFF0000 + 32'(i));
    rd(0, l3(32'hFFFF0000, 32'hFFFF0001, 32'hFFFF0002));
    idle();
    check("idle_rd_valid", SW'(rd_valid), '0);
    check("idle_src_hold", src, l3(32'hFFFF0000, 32'hFFFF0001, 32'hFFFF0002));

    // Window wrapping past DEPTH-1.
    wr1(126, 32'hA);
    wr1(127, 32'hB);
    wr1(0, 32'hC);
    rd(126, l3(32'hA, 32'hB, 32'hC));

    // Burst 120..124 with a two-cycle stall; write_addr/burst_start during BURST ignored.
    bc = 0;
    cyc(1, 1, 1, 4, 120, 32'hEE, 0, 0, '0);
    if (busy) bc++;
    cyc(1, 1, 0, 0, 125, 32'h10, 0, 0, '0); if (busy) bc++;
    cyc(1, 1, 0, 0, 125, 32'h11, 0, 0, '0); if (busy) bc++;
    cyc(1, 1, 0, 0, 125, 32'h12, 0, 0, '0); if (busy) bc++;
    cyc(1, 0, 0, 0, 125, 32'hBAD, 0, 0, '0); if (busy) bc++;
    cyc(1, 0, 1, 0, 125, 32'hBAD, 0, 0, '0); if (busy) bc++;
    cyc(1, 1, 1, 9, 125, 32'h13, 0, 0, '0); if (busy) bc++;
    cyc(1, 1, 0, 0, 125, 32'h14, 0, 0, '0); if (busy) bc++;
    idle();
    if (busy) bc++;
    check("burst_busy_cycles", SW'(bc), SW'(7));
    rd(120, l3(32'h10, 32'h11, 32'h12));
    rd(123, l3(32'h13, 32'h14, 32'h0));

    // Write-first bypass on lane 1.
    cyc(1, 1, 0, 0, 6, 32'h55, 5, 1, l3(32'h0, 32'h55, 32'h0));

    // Reset two beats into a four-beat burst; the write in the reset cycle is dropped.
    cyc(1, 0, 1, 3, 40, 0, 0, 0, '0);
    cyc(1, 1, 0, 0, 0, 32'h40, 0, 0, '0);
    cyc(1, 1, 0, 0, 0, 32'h41, 0, 0, '0);
    check("midburst_busy", SW'(busy), SW'(1));
    rst = 1'b1;
    reg_enable = 1'b1;
    reg_write = 1'b1;
    write_addr = 50;
    write_data = 32'hDEAD;
    tick();
    rst = 1'b0;
    reg_enable = 1'b0;
    reg_write = 1'b0;
    check("abort_busy", SW'(busy), '0);
    check("abort_rd_valid", SW'(rd_valid), '0);
    check("abort_src", src, '0);
    for (int a = 0; a < 128; a += 3) rd(AW'(a), '0);
    wr1(3, 32'h33);
    rd(3, l3(32'h33, 32'h0, 32'h0));

    // Full-depth burst from 100, wrapping 127->0; bypass checked against ptr on beat 0.
    cyc(1, 0, 1, 127, 100, 0, 0, 0, '0);
    cyc(1, 1, 0, 0, 0, 32'h1000, 100, 1, l3(32'h1000, 32'h0, 32'h0));
    for (int i = 1; i < 127; i++) cyc(1, 1, 0, 0, 0, 32'h1000 + 32'(i), 0, 0, '0);
    check("full_busy_before_last", SW'(busy), SW'(1));
    cyc(1, 1, 0, 0, 0, 32'h107F, 0, 0, '0);
    check("full_busy_after_last", SW'(busy), '0);
    for (int a = 0; a < 128; a += 3) rd(AW'(a), l3(fd(a), fd((a + 1) % 128), fd((a + 2) % 128)));
    wr1(9, 32'h77);
    rd(9, l3(32'h77, fd(10), fd(11)));

    idle();
    idle();
    check("scoreboard_drained", SW'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
